// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) feeding a byte FIFO toward the command parser.
// Latency: byte visible on char_out the edge after its stop-bit sample (FIFO empty).
// Backpressure: valid/ready on the FIFO head; full FIFO drops the new byte and pulses overflow.
//
// Ports:
//   clk_in          sole clock, rising edge
//   rst_in          asynchronous active-high reset
//   rx_in           raw serial line, asynchronous to clk_in, idle high
//   char_out        byte at the FIFO head (combinational read of the head entry)
//   char_out_valid  FIFO non-empty
//   char_out_ready  consumer accepts the head byte this cycle
//   fifo_count      current occupancy, 0..FIFO_DEPTH
//   framing_err     one-cycle pulse: stop bit sampled low
//   overflow        one-cycle pulse: received byte dropped because the FIFO was full

module uart_rx_fifo #(
   parameter int BAUD_DIV   = 868,   // clock cycles per bit, >= 4
   parameter int FIFO_DEPTH = 16     // byte entries, power of 2, >= 2
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          rx_in,
   output logic [7:0]                    char_out,
   output logic                          char_out_valid,
   input  logic                          char_out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          framing_err,
   output logic                          overflow
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam int AW = $clog2(FIFO_DEPTH);

   // Mid-bit point of the start bit, and last cycle of a full bit period.
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
   localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_HIGH = 3'd4;

   // ------------------------------------------------------------------
   // Input synchronizer. Both flops reset high so a reset never looks
   // like a falling edge (start bit) on the line.
   // ------------------------------------------------------------------
   logic rx_meta;
   logic rx_s;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_in;
         rx_s    <= rx_meta;
      end
   end

   // ------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------
   logic [2:0]    state;
   logic [CW-1:0] bit_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_reg;

   logic stop_tick;
   logic push_req;
   logic stop_bad;

   // The stop sample is taken combinationally in the last cycle of the
   // stop bit so the FIFO write lands on that same edge.
   assign stop_tick = (state == S_STOP) && (bit_cnt == BIT_LAST);
   assign push_req  = stop_tick && rx_s;
   assign stop_bad  = stop_tick && !rx_s;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!rx_s) begin
                  state   <= S_START;
                  bit_cnt <= '0;
               end
            end

            S_START: begin
               if (bit_cnt == HALF_LAST) begin
                  if (rx_s) begin
                     // Line already back high at mid start bit: a glitch.
                     state <= S_IDLE;
                  end else begin
                     state   <= S_DATA;
                     bit_cnt <= '0;
                     bit_idx <= '0;
                  end
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end

            S_DATA: begin
               if (bit_cnt == BIT_LAST) begin
                  shift_reg[bit_idx] <= rx_s;
                  bit_cnt            <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= S_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end

            S_STOP: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  state   <= rx_s ? S_IDLE : S_WAIT_HIGH;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end

            S_WAIT_HIGH: begin
               // Hold off until the line idles so a break gives one error.
               if (rx_s) begin
                  state <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;

   logic pop;
   logic push_ok;
   logic push_drop;

   assign char_out_valid = (fifo_count != '0);
   assign char_out       = mem[rd_ptr];
   assign pop            = char_out_valid && char_out_ready;

   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign push_ok   = push_req && ((fifo_count < DEPTH) || pop);
   assign push_drop = push_req && !push_ok;

   // Storage carries no reset; char_out is only meaningful while valid.
   always_ff @(posedge clk_in) begin
      if (push_ok) begin
         mem[wr_ptr] <= shift_reg;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop})
            2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
            2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Status pulses, registered so each is exactly one cycle wide.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         framing_err <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         framing_err <= stop_bad;
         overflow    <= push_drop;
      end
   end

endmodule
